// File: rtl/note_lights.sv
// note_lights: multi-channel note indicator LED driver.
// Direct mode follows each channel's note; sustain mode holds full
// brightness after release, then PWM-fades to dark. A new note always
// restarts the channel at full brightness.
module note_lights #(
  parameter int CHANNELS    = 8,
  parameter int CODE_W      = 8,
  parameter int IDLE_CODE   = 99,
  parameter int HOLD_CYCLES = 25_000_000,
  parameter int FADE_STEP   = 1_000_000,
  parameter int PWM_W       = 4
) (
  input  logic                         iClk,
  input  logic                         iReset,
  input  logic                         iMode,
  input  logic [CHANNELS*CODE_W-1:0]   iCodes,
  output logic [CHANNELS-1:0]          oLights,
  output logic                         oAny
);

  localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam int STEP_W = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FADE_STEP - 1);
  localparam logic [PWM_W-1:0]  L_MAX     = '1;
  localparam logic [CODE_W-1:0] IDLE_VAL  = CODE_W'(IDLE_CODE);

  typedef enum logic [1:0] {S_OFF, S_ON, S_HOLD, S_FADE} state_t;

  state_t              state_q [CHANNELS];
  state_t              state_d [CHANNELS];
  logic [HOLD_W-1:0]   hold_q  [CHANNELS];
  logic [HOLD_W-1:0]   hold_d  [CHANNELS];
  logic [STEP_W-1:0]   step_q  [CHANNELS];
  logic [STEP_W-1:0]   step_d  [CHANNELS];
  logic [PWM_W-1:0]    level_q [CHANNELS];
  logic [PWM_W-1:0]    level_d [CHANNELS];
  logic [CODE_W-1:0]   prev_q  [CHANNELS];
  logic [CODE_W-1:0]   prev_d  [CHANNELS];
  logic [PWM_W-1:0]    pwm_cnt_q, pwm_cnt_d;
  logic [CHANNELS-1:0] lights_q, lights_d;
  logic                any_q, any_d;
  logic [CHANNELS-1:0] active, trigger;

  // Per-channel next state, counters and light value from current state.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    for (int k = 0; k < CHANNELS; k++) begin
      prev_d[k]  = iCodes[k*CODE_W +: CODE_W];
      active[k]  = (prev_d[k] != '0) && (prev_d[k] != IDLE_VAL);
      trigger[k] = active[k] && (prev_d[k] != prev_q[k]);

      state_d[k] = state_q[k];
      hold_d[k]  = hold_q[k];
      step_d[k]  = step_q[k];
      level_d[k] = level_q[k];

      if (!iMode) begin
        // Direct mode: plain follower, any sustain in progress is dropped.
        state_d[k] = active[k] ? S_ON : S_OFF;
        hold_d[k]  = '0;
        step_d[k]  = '0;
        level_d[k] = '0;
      end else begin
        case (state_q[k])
          S_OFF: begin
            if (active[k]) state_d[k] = S_ON;
          end
          S_ON: begin
            if (!active[k]) begin
              hold_d[k] = '0;
              if (HOLD_CYCLES == 0) begin
                state_d[k] = S_FADE;
                level_d[k] = L_MAX;
                step_d[k]  = '0;
              end else begin
                state_d[k] = S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (trigger[k] || active[k]) begin
              state_d[k] = S_ON;
              hold_d[k]  = '0;
            end else if (hold_q[k] == HOLD_LAST) begin
              state_d[k] = S_FADE;
              hold_d[k]  = '0;
              level_d[k] = L_MAX;
              step_d[k]  = '0;
            end else begin
              hold_d[k] = hold_q[k] + HOLD_W'(1);
            end
          end
          S_FADE: begin
            if (trigger[k] || active[k]) begin
              state_d[k] = S_ON;
              step_d[k]  = '0;
              level_d[k] = '0;
            end else if (step_q[k] == STEP_LAST) begin
              step_d[k] = '0;
              if (level_q[k] == PWM_W'(1)) begin
                state_d[k] = S_OFF;
                level_d[k] = '0;
              end else begin
                level_d[k] = level_q[k] - PWM_W'(1);
              end
            end else begin
              step_d[k] = step_q[k] + STEP_W'(1);
            end
          end
          default: state_d[k] = S_OFF;
        endcase
      end

      case (state_q[k])
        S_ON, S_HOLD: lights_d[k] = 1'b1;
        S_FADE:       lights_d[k] = (pwm_cnt_q < level_q[k]);
        default:      lights_d[k] = 1'b0;
      endcase
    end
    any_d = |lights_d;
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      for (int k = 0; k < CHANNELS; k++) begin
        state_q[k] <= S_OFF;
        hold_q[k]  <= '0;
        step_q[k]  <= '0;
        level_q[k] <= '0;
        prev_q[k]  <= '0;
      end
      pwm_cnt_q <= '0;
      lights_q  <= '0;
      any_q     <= 1'b0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        state_q[k] <= state_d[k];
        hold_q[k]  <= hold_d[k];
        step_q[k]  <= step_d[k];
        level_q[k] <= level_d[k];
        prev_q[k]  <= prev_d[k];
      end
      pwm_cnt_q <= pwm_cnt_d;
      lights_q  <= lights_d;
      any_q     <= any_d;
    end
  end

  assign oLights = lights_q;
  assign oAny    = any_q;

endmodule

// File: doc/note_lights.md
# note_lights

Multi-channel LED driver for the piano's note indicators, superseding the single-channel light blocks. Each of CHANNELS note-code inputs drives one LED. In direct mode an LED is lit exactly while its note is playing. In sustain mode an LED holds full brightness for a programmable time after release, then fades to dark with PWM, and restarts on any new note. It sits between the note decoder/keyboard scanner and the board LED pins.

## Interface
- CHANNELS, 8, number of independent note channels/LEDs (1..16)
- CODE_W, 8, width of each note code
- IDLE_CODE, 99, extra code value treated as "no note" (0 is always "no note")
- HOLD_CYCLES, 25_000_000, full-brightness cycles after release (0 = skip hold)
- FADE_STEP, 1_000_000, cycles per brightness decrement during fade (>=1)
- PWM_W, 4, brightness/PWM counter width; max level L_MAX = 2^PWM_W-1

- iClk  in  1  system clock, all logic on rising edge
- iReset  in  1  synchronous, active-high reset
- iMode  in  1  0 = direct, 1 = sustain (hold + fade)
- iCodes  in  CHANNELS*CODE_W  flattened note codes; channel k = bits [k*CODE_W +: CODE_W]
- oLights  out  CHANNELS  LED drive, bit k = channel k
- oAny  out  1  OR of the next-cycle oLights value, registered alongside oLights

## Operation
- Channel k is active when code_k != 0 and code_k != IDLE_CODE.
- Each channel has a registered previous code prev_k. A trigger occurs when the channel is active and code_k != prev_k. This covers inactive->active and one active note changing to another.
- Per-channel FSM has states OFF, ON, HOLD and FADE, with a hold counter (width clog2(HOLD_CYCLES+1)), a step counter (width clog2(FADE_STEP)) and a level register (PWM_W bits).
- OFF: if active, go to ON.
- ON: if inactive, go to HOLD with hold counter = 0. If HOLD_CYCLES = 0, go straight to FADE.
- HOLD: a trigger or an active input returns the channel to ON. Otherwise the hold counter increments. At HOLD_CYCLES-1 the channel goes to FADE with level = L_MAX and step counter = 0.
- FADE: a trigger or an active input returns the channel to ON. Otherwise the step counter increments. At FADE_STEP-1 the step counter clears and level decrements. If level is 1 at that point, go to OFF with level = 0.
- Total fade time is L_MAX*FADE_STEP cycles.
- In direct mode (iMode = 0), the next state is ON when active and OFF otherwise. A channel in HOLD or FADE goes to OFF on the next edge. All counters clear.
- The mode is sampled every cycle; switching mode mid-fade takes effect on the next edge.
- One shared free-running counter pwm_cnt (PWM_W bits) wraps from L_MAX to 0.
- Light value per channel: ON = 1, HOLD = 1, OFF = 0, FADE = (pwm_cnt < level).
- oLights and oAny are registered; there are no combinational paths from inputs to outputs.
- Channels are fully independent apart from sharing pwm_cnt.

## Timing
- Reset: all FSMs OFF, all counters 0, prev_k = 0, pwm_cnt = 0, oLights = 0, oAny = 0. Reset mid-fade or mid-hold overrides everything on that edge.
- The first edge after reset deasserts evaluates inputs normally.
- Latency: a code change sampled at edge N drives the state at N, so oLights reflects it after edge N+1.
- Direct mode therefore behaves as a 2-cycle registered follower: input to state, then state to output.
- Release in sustain mode: oLights stays 1 for HOLD_CYCLES cycles beyond direct-mode behaviour, then PWM-fades.
- Simultaneous events:
  - A trigger on the same edge as the HOLD->FADE or FADE->OFF transition wins: the channel goes to ON.
  - A reset on the same edge as a trigger resolves to reset.
- Codes held constant generate no retriggers. A code returning to 0 and then to the same value does retrigger.

## Test plan
Bench parameters: CHANNELS=4, CODE_W=8, HOLD_CYCLES=4, FADE_STEP=2, PWM_W=2 (L_MAX=3).

- Reset: hold iReset=1 for 3 cycles with all channels at code 5 -> oLights=0000, oAny=0 throughout. The first release edge followed by 2 more edges gives oLights=1111.
- Direct mode and idle codes: iMode=0, ch0 code 0->7->99->0 with each step lasting 5 cycles -> oLights[0] = 0, 1 (2 cycles late), 0, 0. Nothing is lit for 99.
- Sustain release: iMode=1, ch1 code 12 for 5 cycles then 0. oLights[1] stays 1 for 4 extra cycles, then fades over 6 cycles with levels 3,3,2,2,1,1 against pwm_cnt. It is then 0 with the FSM in OFF.
- Retrigger mid-fade: ch2 at level 2 in FADE receives code 40 -> ON next edge, oLights[2]=1 constant. Releasing again restarts a full 4-cycle hold.
- Note change without release: ch3 code 10->11 directly -> a trigger is detected and oLights[3] stays 1 with no glitch.
- Mode switch mid-fade and simultaneity: ch0 in FADE, iMode drops to 0 -> OFF next edge, with oLights[0]=0 one edge later. Separately, iReset=1 on the same edge as a trigger -> state OFF and outputs 0.
